// File: rtl/pcie_byte_framer.sv
// rtl/pcie_byte_framer.sv - transmit byte framer: store-and-forward payload FIFO feeding a COM/SKP/STP/SDP/END/IDL symbol sequencer
module pcie_byte_framer #(
    parameter int COM_LEN      = 4,
    parameter int SKP_LEN      = 12,
    parameter int SKP_INTERVAL = 64,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic       clk_250k,
    input  logic       reset_L,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_eop,
    input  logic       in_type,
    output logic       in_ready,
    output logic       valid,
    output logic [7:0] data,
    output logic       k_char,
    output logic       err
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int MAXLEN = (COM_LEN > SKP_LEN) ? COM_LEN : SKP_LEN;
    localparam int CNT_W  = $clog2(MAXLEN + 1);
    localparam int TW     = $clog2(SKP_INTERVAL + 1);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SKP_COM,
        S_SKP,
        S_START,
        S_PAYLOAD,
        S_END
    } state_t;

    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_pkt_cnt;
    logic             r_in_pkt;
    logic             r_type;
    logic             r_run;
    logic             r_err;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TW-1:0]    r_skp_tmr;
    logic             r_valid;
    logic [7:0]       r_data;
    logic             r_k;

    logic [AW:0]      w_count;
    logic             w_full;
    logic             w_flush;
    logic             w_wr;
    logic             w_rd;
    logic [9:0]       w_head;
    logic             w_wr_type;
    logic             w_wr_eop;
    logic             w_rd_eop;
    logic             w_skp_due;
    logic             w_at_decide;
    state_t           w_decide;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
    // A full buffer with no complete packet can never drain: oversize packet.
    assign w_flush   = w_full && (r_pkt_cnt == '0);
    assign in_ready  = r_run && !w_full && !w_flush;
    assign w_wr      = in_valid && in_ready;
    assign w_rd      = (r_state == S_PAYLOAD);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_type = r_in_pkt ? r_type : in_type;
    assign w_wr_eop  = w_wr && in_eop;
    assign w_rd_eop  = w_rd && w_head[9];
    assign w_skp_due = (r_skp_tmr == TW'(SKP_INTERVAL));

    assign w_at_decide = (r_state == S_IDLE) || (r_state == S_END) ||
                         ((r_state == S_INIT) && (r_cnt == CNT_W'(COM_LEN - 1))) ||
                         ((r_state == S_SKP)  && (r_cnt == CNT_W'(SKP_LEN - 1)));

    always_comb begin
        w_decide = S_IDLE;
        if (w_skp_due)
            w_decide = S_SKP_COM;
        else if (r_pkt_cnt != '0)
            w_decide = S_START;
    end

    always_ff @(posedge clk_250k) begin
        if (w_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= {in_eop, w_wr_type, in_data};
    end

    always_ff @(posedge clk_250k) begin
        if (!reset_L) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pkt_cnt <= '0;
            r_in_pkt  <= 1'b0;
            r_type    <= 1'b0;
            r_run     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_in_pkt <= 1'b0;
                r_type   <= 1'b0;
                r_err    <= 1'b1;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                    r_in_pkt <= !in_eop;
                    r_type   <= w_wr_type;
                end
                if (w_rd)
                    r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                case ({w_wr_eop, w_rd_eop})
                    2'b10:   r_pkt_cnt <= r_pkt_cnt + (AW+1)'(1);
                    2'b01:   r_pkt_cnt <= r_pkt_cnt - (AW+1)'(1);
                    default: r_pkt_cnt <= r_pkt_cnt;
                endcase
            end
        end
    end

    // Output registers follow the state one edge later; decisions use pre-edge counters.
    always_ff @(posedge clk_250k) begin
        if (!reset_L) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_skp_tmr <= '0;
            r_valid   <= 1'b0;
            r_data    <= 8'h00;
            r_k       <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            if (w_at_decide && w_skp_due)
                r_skp_tmr <= '0;
            else if (!w_skp_due)
                r_skp_tmr <= r_skp_tmr + TW'(1);

            case (r_state)
                S_INIT: begin
                    r_data <= SYM_COM;
                    r_k    <= 1'b1;
                    if (r_cnt == CNT_W'(COM_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= w_decide;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    r_data  <= SYM_IDL;
                    r_k     <= 1'b1;
                    r_state <= w_decide;
                end
                S_SKP_COM: begin
                    r_data <= SYM_COM;
                    r_k    <= 1'b1;
                    if (r_cnt == CNT_W'(COM_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_SKP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SKP: begin
                    r_data <= SYM_SKP;
                    r_k    <= 1'b1;
                    if (r_cnt == CNT_W'(SKP_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= w_decide;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_START: begin
                    r_data  <= w_head[8] ? SYM_SDP : SYM_STP;
                    r_k     <= 1'b1;
                    r_state <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    r_data <= w_head[7:0];
                    r_k    <= 1'b0;
                    if (w_head[9])
                        r_state <= S_END;
                end
                S_END: begin
                    r_data  <= SYM_END;
                    r_k     <= 1'b1;
                    r_state <= w_decide;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign valid  = r_valid;
    assign data   = r_data;
    assign k_char = r_k;
    assign err    = r_err;

endmodule

// File: doc/pcie_byte_framer.md
# pcie_byte_framer

Transmit-side framer for the byte-wide symbol stream of the link. Accepts packet payload bytes from the upstream logic and buffers each packet until it is complete. Emits one continuous byte stream on the 250 kHz domain with these symbols:
- start-up COM ordered set;
- STP/SDP…END framing around each packet;
- periodic COM+SKP ordered sets between packets;
- IDL fill when there is nothing to send.

The output drives the symbol demultiplexer, which splits the stream back into data and control.

## Interface
Parameters:
- COM_LEN, 4: COM symbols per ordered set.
- SKP_LEN, 12: SKP symbols following the COM symbols of a skip ordered set.
- SKP_INTERVAL, 64: cycles between skip-set requests.
- FIFO_DEPTH, 32: payload buffer entries (power of 2).

Ports:
- clk_250k  in  1  single clock. Everything is on the rising edge.
- reset_L  in  1  synchronous, active-low reset.
- in_valid  in  1  payload byte present.
- in_data  in  8  payload byte.
- in_eop  in  1  marks the last byte of a packet.
- in_type  in  1  packet type, sampled on the first byte of a packet: 0 = TLP (STP), 1 = DLLP (SDP).
- in_ready  out  1  buffer can accept a byte. A byte transfers when in_valid && in_ready.
- valid  out  1  output symbol valid.
- data  out  8  output symbol.
- k_char  out  1  1 when data is a control symbol, 0 when it is payload.
- err  out  1  sticky oversize-packet error.

Symbol codes: COM 0xBC, SKP 0x1C, STP 0xFB, SDP 0x5C, END 0xFD, IDL 0x7C.

## Operation
- **Payload FIFO**
  - Each entry is 10 bits: {eop, type, data}.
  - The first byte after reset, or after an eop byte, starts a packet. Its in_type is latched and stored with every byte of that packet.
  - in_ready = !full && !flush.
- **Packet counter (pkt_cnt)**
  - +1 on a write of an eop byte; −1 on a read of an eop byte; unchanged when both happen in the same cycle.
  - A packet is eligible only when pkt_cnt > 0 (store-and-forward, so the output never has a gap inside a packet).
- **Skip timer**
  - Counts every cycle and saturates at SKP_INTERVAL, which sets skp_due.
  - Cleared when the state machine enters SKP_COM.
- **State machine.** The registered output reflects the current state.
  - INIT: COM_LEN × (COM, k=1), then → DECIDE.
  - DECIDE is evaluated at the end of IDLE, END, INIT and SKP, in this priority:
    1. skp_due → SKP_COM.
    2. pkt_cnt > 0 → START.
    3. otherwise → IDLE.
  - IDLE: outputs IDL, k=1, for one cycle, then DECIDE.
  - SKP_COM: COM_LEN × COM, then SKP: SKP_LEN × SKP (k=1), then DECIDE.
  - START: outputs STP (type 0) or SDP (type 1), k=1, taken from the head entry. No FIFO read in this state.
  - PAYLOAD: pops one entry per cycle and outputs its data with k=0. When the popped entry has eop=1 → END.
  - END: outputs END, k=1, then DECIDE. Back-to-back packets therefore give …END, STP… with no IDL between them.
- A skip set is never inserted inside a packet. A skp_due raised during PAYLOAD waits for the next DECIDE.
- **Oversize packet:** if the FIFO is full and pkt_cnt == 0:
  - set err (sticky until reset);
  - flush the FIFO for one cycle (pointers cleared, in_ready = 0);
  - clear the partial-packet type latch.
- Payload bytes equal to control codes are legal; they carry k=0.

## Timing
- While reset_L = 0 at an edge, outputs take these values at that edge:
  - valid = 0, data = 0x00, k_char = 0, err = 0, in_ready = 0;
  - FIFO empty, pkt_cnt = 0, skip timer = 0, state = INIT.
- After the first edge with reset_L = 1: valid = 1 permanently and in_ready = 1.
- COM appears on the output at edges 1 through COM_LEN after reset release.
- Eop byte written at edge N with the state machine at a DECIDE point at edge N+1 → START output at edge N+2.
- After START, payload bytes appear on consecutive edges. END follows the last byte by exactly one edge.
- Packet of L bytes occupies L+2 output cycles.
- Simultaneous FIFO write and read are allowed at any occupancy except full (write is blocked when full).
- Reset asserted mid-packet aborts the packet. No END is emitted; the first output after release is INIT COM.

## Test plan
- Reset released, no input → 4×COM, then IDL on every cycle until cycle 64, then 4×COM + 12×SKP, then IDL again.
- TLP {0x01, 0x02} written (type 0) → STP, 01, 02, END with k = 1, 0, 0, 1. STP appears 2 cycles after the eop write.
- Two packets queued back-to-back (TLP 0x03..0x0C, then DLLP {0x0D, 0x0E}) → STP 03…0C END SDP 0D 0E END with no IDL between the packets.
- Packet still streaming when skp_due fires → packet completes intact, then 4×COM + 12×SKP, then the next pending packet.
- Payload byte 0xBC → output 0xBC with k_char = 0. Then a 33-byte packet with no eop → err = 1, FIFO flushed, in_ready low for 1 cycle, output stays IDL.
